unpack: RTL and testbench

Frame decoder directly downstream of the UART receiver. Consumes the receiver's byte stream over a stb/rdy handshake and locates frames by a sync byte and a length byte. Assembles little-endian payload bytes into WIDTH-bit words and presents them over a stb/rdy handshake to the network loader, flagging the last word of each frame.

---
 rtl/machina_pkg.sv | 13 +
 rtl/unpack_sum.sv | 25 ++
 rtl/unpack.sv | 132 +++++++++++++
 tb/tb_unpack.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/machina_pkg.sv
// Shared framing definitions for the unpack/pack pair: state encoding and default sync byte.
package machina_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } frame_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/unpack_sum.sv
// 8-bit wrapping running sum; zero flags that adding the current byte would wrap the sum to 0.
module unpack_sum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] dat,
  output logic [7:0] sum,
  output logic       zero
);

  // clr together with add seeds the sum with dat, which is how the length byte starts it
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= 8'h00;
    end else if (clr) begin
      sum <= add ? dat : 8'h00;
    end else if (add) begin
      sum <= sum + dat;
    end
  end

  assign zero = ((sum + dat) == 8'h00);

endmodule

// File: rtl/unpack.sv
// Frame decoder: SYNC, length N, N little-endian WIDTH-bit words, optional checksum byte.
// Define UNPACK_CHECKSUM_EN to add the CHK byte, running sum and err pulse.
module unpack
  import machina_pkg::*;
#(
  parameter int         WIDTH = 16,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_stb,
  input  logic [7:0]       in_dat,
  output logic             in_rdy,
  output logic             out_stb,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_lst,
  input  logic             out_rdy,
  output logic             err
);

  localparam int BYTES = WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

`ifdef UNPACK_CHECKSUM_EN
  localparam frame_state_t AFTER_FRAME = CHK;
`else
  localparam frame_state_t AFTER_FRAME = HUNT;
`endif

  frame_state_t     state, state_nx;
  logic [7:0]       n;
  logic [7:0]       wcnt;
  logic [IW-1:0]    bidx;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] word;
  logic             acc;
  logic             word_done;
  logic             last;

  assign in_rdy    = (state == DATA) ? ~out_stb : 1'b1;
  assign acc       = in_stb & in_rdy;
  assign word_done = (state == DATA) && acc && (bidx == LAST_IDX);
  assign last      = (wcnt == n - 8'd1);

  // The final byte of a word bypasses the partial register straight into the top lane
  always_comb begin
    word = part;
    word[WIDTH-1 -: 8] = in_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      HUNT: if (acc && (in_dat == SYNC)) state_nx = LEN;
      LEN:  if (acc) state_nx = (in_dat != 8'd0) ? DATA : AFTER_FRAME;
      DATA: if (word_done && last) state_nx = AFTER_FRAME;
      CHK:  if (acc) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  // Word assembly and output register; a pending word blocks DATA bytes via in_rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb <= 1'b0;
      out_dat <= '0;
      out_lst <= 1'b0;
      n       <= 8'd0;
      wcnt    <= 8'd0;
      bidx    <= '0;
      part    <= '0;
    end else begin
      if (out_stb && out_rdy) begin
        out_stb <= 1'b0;
      end
      if ((state == LEN) && acc) begin
        n    <= in_dat;
        wcnt <= 8'd0;
        bidx <= '0;
      end
      if ((state == DATA) && acc) begin
        if (bidx == LAST_IDX) begin
          out_dat <= word;
          out_stb <= 1'b1;
          out_lst <= last;
          wcnt    <= wcnt + 8'd1;
          bidx    <= '0;
        end else begin
          for (int k = 0; k < BYTES; k++) begin
            if (bidx == IW'(k)) part[8*k +: 8] <= in_dat;
          end
          bidx <= bidx + IW'(1);
        end
      end
    end
  end

`ifdef UNPACK_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_zero;

  unpack_sum u_sum (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == LEN) && acc),
    .add  (acc && ((state == LEN) || (state == DATA))),
    .dat  (in_dat),
    .sum  (sum),
    .zero (sum_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (state == CHK) && acc && !sum_zero;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unpack.sv
// Scoreboard bench for unpack (WIDTH=16); err expectations follow UNPACK_CHECKSUM_EN.
module tb_unpack;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] dat;
    logic        lst;
  } word_t;

  logic        clk;
  logic        rst;
  logic        in_stb;
  logic [7:0]  in_dat;
  logic        in_rdy;
  logic        out_stb;
  logic [15:0] out_dat;
  logic        out_lst;
  logic        out_rdy;
  logic        err;

  word_t expQ[$];
  word_t obsQ[$];
  int    errPulses = 0;
  int    errBase   = 0;
  int    vectors   = 0;
  int    miscompares = 0;

  unpack #(.WIDTH(16), .SYNC(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_stb  (in_stb),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_stb (out_stb),
    .out_dat (out_dat),
    .out_lst (out_lst),
    .out_rdy (out_rdy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every transferred word and every cycle err is high
  always @(negedge clk) begin
    if (out_stb && out_rdy) obsQ.push_back('{dat: out_dat, lst: out_lst});
    if (err) errPulses++;
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bit sent = 0;
    for (int c = 0; c < 200 && !sent; c++) begin
      @(negedge clk);
      if (in_rdy) begin
        in_stb = 1'b1;
        in_dat = b;
        @(posedge clk);
        #1 in_stb = 1'b0;
        sent = 1;
      end
    end
    if (!sent) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL send_timeout: observed in_rdy low for 200 cycles expected byte %0h accepted", b);
    end
  endtask

  task automatic sendSeq(input bq_t s);
    foreach (s[i]) applyStimulus(s[i]);
  endtask

  function automatic logic expErr(input bq_t body);
    logic [7:0] sum = 8'h00;
    foreach (body[i]) sum = sum + body[i];
`ifdef UNPACK_CHECKSUM_EN
    return (sum != 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic expectWord(input logic [15:0] d, input logic l);
    expQ.push_back('{dat: d, lst: l});
  endtask

  task automatic checkOutput(input string tag, input logic errExp);
    int n;
    word_t o, e;
    repeat (6) @(negedge clk);
    compare({tag, "_nwords"}, obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      compare($sformatf("%s_dat%0d", tag, i), {16'h0, o.dat}, {16'h0, e.dat});
      compare($sformatf("%s_lst%0d", tag, i), {31'h0, o.lst}, {31'h0, e.lst});
    end
    compare({tag, "_err"}, errPulses - errBase, {31'h0, errExp});
    obsQ.delete();
    expQ.delete();
    errBase = errPulses;
  endtask

  initial begin
    bq_t s;
    bit stable;
    rst = 1'b1;
    in_stb = 1'b0;
    in_dat = 8'h00;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare("rst_out_stb", {31'h0, out_stb}, 32'h0);
    compare("rst_out_dat", {16'h0, out_dat}, 32'h0);
    compare("rst_out_lst", {31'h0, out_lst}, 32'h0);
    compare("rst_err", {31'h0, err}, 32'h0);
    compare("rst_in_rdy", {31'h0, in_rdy}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    errBase = errPulses;

    // Two-word frame, good checksum
    s = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA};
    expectWord(16'h1234, 1'b0);
    expectWord(16'h5678, 1'b1);
    sendSeq(s);
    checkOutput("good2", expErr('{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA}));

    // Same frame with a corrupted checksum
    s = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEB};
    expectWord(16'h1234, 1'b0);
    expectWord(16'h5678, 1'b1);
    sendSeq(s);
    checkOutput("badchk", expErr('{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEB}));

    // Leading junk discarded, single-word frame
    s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h87};
    expectWord(16'hABCD, 1'b1);
    sendSeq(s);
    checkOutput("junk", expErr('{8'h01, 8'hCD, 8'hAB, 8'h87}));

    // Back-pressure: hold out_rdy low with the first word pending
    @(posedge clk);
    #1 out_rdy = 1'b0;
    expectWord(16'h1234, 1'b0);
    expectWord(16'h5678, 1'b1);
    s = '{8'hA5, 8'h02, 8'h34, 8'h12};
    sendSeq(s);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(in_rdy == 1'b0 && out_stb == 1'b1 && out_dat == 16'h1234 && out_lst == 1'b0)) stable = 0;
    end
    compare("stall_hold", {31'h0, stable}, 32'h1);
    compare("stall_nowords", obsQ.size(), 32'h0);
    @(posedge clk);
    #1 out_rdy = 1'b1;
    s = '{8'h78, 8'h56, 8'hEA};
    sendSeq(s);
    checkOutput("stall", expErr('{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA}));

    // Empty frame, then a fresh frame right behind it
    s = '{8'hA5, 8'h00, 8'h00};
    sendSeq(s);
    checkOutput("empty", expErr('{8'h00, 8'h00}));
    s = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'hB9};
    expectWord(16'h1234, 1'b1);
    sendSeq(s);
    checkOutput("after_empty", expErr('{8'h01, 8'h34, 8'h12, 8'hB9}));

    // Reset in the middle of a frame discards it
    s = '{8'hA5, 8'h02, 8'h34};
    sendSeq(s);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("midrst_out_stb", {31'h0, out_stb}, 32'h0);
    compare("midrst_in_rdy", {31'h0, in_rdy}, 32'h1);
    compare("midrst_out_lst", {31'h0, out_lst}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    s = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'hDD};
    expectWord(16'h2211, 1'b1);
    sendSeq(s);
    checkOutput("postrst", expErr('{8'h01, 8'h11, 8'h22, 8'hDD}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
